// File: rtl/chan_err_inj.sv
// rtl/chan_err_inj.sv - channel error injector between a convolutional encoder and decoder
//
// Sits on a 2-bit symbol stream and flips both bits of a symbol with probability
// 2^-N per valid symbol, using a 32-bit Galois LFSR as the random source.
// It also keeps window statistics on how many bits were corrupted.
//
// Optional feature macro: CHAN_ERR_INJ_BURST_EN
//   defined   : a hit arms a BURST state, so the next valid symbol is also corrupted
//   undefined : every corruption is a single isolated symbol; the FSM stays in CLEAN
//
// Parameters
//   N          error-rate exponent, legal range 1..16
//   LFSR_SEED  nonzero LFSR value loaded at reset
//   CNT_W      width of the statistics counters
//   WINDOW     number of valid symbols in the statistics window, WINDOW < 2^CNT_W
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   sym_i          encoder symbol {g1,g0}
//   valid_i        sym_i qualifier
//   inject_en_i    runtime enable for error injection
//   sym_o          registered, possibly corrupted symbol
//   valid_o        sym_o qualifier, valid_i delayed by one cycle
//   err_inj_o      XOR mask applied to the symbol on sym_o
//   bad_bit_ct_o   corrupted bits counted within the window (saturating)
//   word_ct_o      valid symbols counted, saturating at WINDOW
//   window_done_o  sticky flag, high from the cycle after word_ct_o reaches WINDOW

module chan_err_inj #(
   parameter int          N         = 4,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
   parameter int          CNT_W     = 16,
   parameter int          WINDOW    = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sym_i,
   input  logic             valid_i,
   input  logic             inject_en_i,
   output logic [1:0]       sym_o,
   output logic             valid_o,
   output logic [1:0]       err_inj_o,
   output logic [CNT_W-1:0] bad_bit_ct_o,
   output logic [CNT_W-1:0] word_ct_o,
   output logic             window_done_o
);

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0]      POLY    = 32'h8020_0003;
   localparam logic [CNT_W-1:0] WIN_CT  = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      CLEAN = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_next;
   logic             hit;
   logic [1:0]       mask;
   logic [1:0]       mask_pc;
   logic             count_en;
   logic [CNT_W:0]   bad_sum;

   // Hit decision uses the LFSR value before this cycle's advance
   assign hit = valid_i & inject_en_i & (&lfsr[N-1:0]);

   // The LFSR only moves on valid symbols, so idle cycles never change the
   // sequence of random decisions seen by the symbol stream
   always_comb begin
      lfsr_next = lfsr;
      if (valid_i) begin
         lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0000_0000);
      end
   end

   always_comb begin
      state_next = state;
      mask       = 2'b00;
      case (state)
         CLEAN: begin
            if (hit) begin
               mask = 2'b11;
`ifdef CHAN_ERR_INJ_BURST_EN
               state_next = BURST;
`endif
            end
         end
         BURST: begin
`ifdef CHAN_ERR_INJ_BURST_EN
            // Dropping the enable cancels the pending burst without corrupting.
            // Otherwise wait (across idle cycles) for the next valid symbol and
            // force it corrupt; a hit on that same symbol does not re-arm.
            if (!inject_en_i) begin
               state_next = CLEAN;
            end else if (valid_i) begin
               mask       = 2'b11;
               state_next = CLEAN;
            end
`else
            state_next = CLEAN;
`endif
         end
         default: state_next = CLEAN;
      endcase
   end

   // Statistics only cover the first WINDOW valid symbols after reset
   assign count_en = valid_i & (word_ct_o < WIN_CT);
   assign mask_pc  = {1'b0, mask[1]} + {1'b0, mask[0]};
   assign bad_sum  = {1'b0, bad_bit_ct_o} + (CNT_W+1)'(mask_pc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAN;
         lfsr  <= LFSR_SEED;
      end else begin
         state <= state_next;
         lfsr  <= lfsr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sym_o     <= 2'b00;
         valid_o   <= 1'b0;
         err_inj_o <= 2'b00;
      end else begin
         valid_o <= valid_i;
         // sym_o and err_inj_o hold across idle cycles
         if (valid_i) begin
            sym_o     <= sym_i ^ mask;
            err_inj_o <= mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_ct_o     <= '0;
         bad_bit_ct_o  <= '0;
         window_done_o <= 1'b0;
      end else begin
         if (count_en) begin
            word_ct_o <= word_ct_o + 1'b1;
            if (bad_sum > {1'b0, CNT_MAX}) begin
               bad_bit_ct_o <= CNT_MAX;
            end else begin
               bad_bit_ct_o <= bad_sum[CNT_W-1:0];
            end
         end
         // Registered compare gives the one-cycle lag behind word_ct_o; sticky until reset
         if (word_ct_o == WIN_CT) begin
            window_done_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_chan_err_inj.sv
// tb/tb_chan_err_inj.sv - self-checking bench for chan_err_inj
module tb_chan_err_inj;

   localparam logic [31:0] SEED = 32'hACE1_0001;
   localparam logic [31:0] POLY = 32'h8020_0003;

`ifdef CHAN_ERR_INJ_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sym;
   logic        valid;
   logic        inj;

   logic [1:0]  sym_o, err_o;
   logic        valid_o, done_o;
   logic [15:0] bad_ct, word_ct;

   logic [1:0]  sym_o2, err_o2;
   logic        valid_o2, done_o2;
   logic [3:0]  bad_ct2, word_ct2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_lfsr;
   bit          m_burst;
   int          m_word, m_bad, m2_word, m2_bad;

   always #5 clk = ~clk;

   chan_err_inj #(.N(1), .LFSR_SEED(SEED), .CNT_W(16), .WINDOW(256)) dut (
      .clk(clk), .rst(rst), .sym_i(sym), .valid_i(valid), .inject_en_i(inj),
      .sym_o(sym_o), .valid_o(valid_o), .err_inj_o(err_o),
      .bad_bit_ct_o(bad_ct), .word_ct_o(word_ct), .window_done_o(done_o)
   );

   // Small counters so bad_bit_ct saturation is reachable inside the window
   chan_err_inj #(.N(1), .LFSR_SEED(SEED), .CNT_W(4), .WINDOW(12)) dut2 (
      .clk(clk), .rst(rst), .sym_i(sym), .valid_i(valid), .inject_en_i(inj),
      .sym_o(sym_o2), .valid_o(valid_o2), .err_inj_o(err_o2),
      .bad_bit_ct_o(bad_ct2), .word_ct_o(word_ct2), .window_done_o(done_o2)
   );

   typedef struct {
      logic        v;
      logic        i;
      logic [1:0]  s;
      logic [1:0]  e_sym;
      logic [1:0]  e_err;
      logic        e_val;
      logic [15:0] e_word;
      logic [15:0] e_bad;
      logic [31:0] e_lfsr;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic i, input logic [1:0] s);
      valid = v;
      inj   = i;
      sym   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      inj   = 1'b0;
      sym   = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_lfsr  = SEED;
      m_burst = 1'b0;
      m_word  = 0;
      m_bad   = 0;
      m2_word = 0;
      m2_bad  = 0;
   endtask

   task automatic model_step(input logic v, input logic in_en, output logic [1:0] mask);
      logic hit;
      int   pc;
      mask = 2'b00;
      hit  = v & in_en & m_lfsr[0];
      if (BURST_ON && m_burst) begin
         if (!in_en) m_burst = 1'b0;
         else if (v) begin
            mask    = 2'b11;
            m_burst = 1'b0;
         end
      end else if (hit) begin
         mask    = 2'b11;
         m_burst = BURST_ON;
      end
      pc = (mask == 2'b11) ? 2 : 0;
      if (v) begin
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
         if (m_word < 256) begin
            m_word++;
            m_bad = (m_bad + pc > 65535) ? 65535 : m_bad + pc;
         end
         if (m2_word < 12) begin
            m2_word++;
            m2_bad = (m2_bad + pc > 15) ? 15 : m2_bad + pc;
         end
      end
   endtask

   initial begin
      logic [1:0] mk;
      logic [1:0] s;
      logic       prev_v;
      bit         found;

      // Hand-computed: seed bit0 sequence per valid symbol is 1,1,0,1,1,0,1,1,0,...
      tbl[0]  = '{1'b1, 1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 16'd1, 16'd2,  32'hD650_8003};
      tbl[1]  = '{1'b1, 1'b1, 2'b10, 2'b01, 2'b11, 1'b1, 16'd2, 16'd4,  32'hEB08_4002};
      tbl[2]  = '{1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 16'd3, 16'd4,  32'h7584_2001};
      tbl[3]  = '{1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 16'd3, 16'd4,  32'h7584_2001};
      tbl[4]  = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 1'b1, 16'd4, 16'd6,  32'hBAE2_1003};
      tbl[5]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 16'd5, 16'd6,  32'hDD51_0802};
      tbl[6]  = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 16'd6, 16'd6,  32'h6EA8_8401};
      tbl[7]  = '{1'b1, 1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 16'd7, 16'd8,  32'hB774_4203};
      tbl[8]  = '{1'b0, 1'b1, 2'b00, 2'b10, 2'b11, 1'b0, 16'd7, 16'd8,  32'hB774_4203};
      tbl[9]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b11, 1'b0, 16'd7, 16'd8,  32'hB774_4203};
      tbl[10] = '{1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 1'b1, 16'd8, 16'd10, 32'hDB9A_2102};
      tbl[11] = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 16'd9, 16'd10, 32'h6DCD_1081};

      rst = 1'b1; valid = 1'b0; inj = 1'b0; sym = 2'b00;

      // Reset state
      do_reset();
      check("rst_sym",   32'(sym_o),   32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_err",   32'(err_o),   32'd0);
      check("rst_bad",   32'(bad_ct),  32'd0);
      check("rst_word",  32'(word_ct), 32'd0);
      check("rst_done",  32'(done_o),  32'd0);
      check("rst_lfsr",  dut.lfsr,     SEED);

      // Directed table
      for (int k = 0; k < 12; k++) begin
         drive(tbl[k].v, tbl[k].i, tbl[k].s);
         check($sformatf("tbl%0d_sym", k),   32'(sym_o),   32'(tbl[k].e_sym));
         check($sformatf("tbl%0d_err", k),   32'(err_o),   32'(tbl[k].e_err));
         check($sformatf("tbl%0d_valid", k), 32'(valid_o), 32'(tbl[k].e_val));
         check($sformatf("tbl%0d_word", k),  32'(word_ct), 32'(tbl[k].e_word));
         check($sformatf("tbl%0d_bad", k),   32'(bad_ct),  32'(tbl[k].e_bad));
         check($sformatf("tbl%0d_done", k),  32'(done_o),  32'd0);
         check($sformatf("tbl%0d_lfsr", k),  dut.lfsr,     tbl[k].e_lfsr);
      end

      // Injection disabled: 300 symbols pass untouched, window fills
      do_reset();
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 1'b0, 2'b01);
         check("noinj_sym", 32'(sym_o), 32'd1);
         check("noinj_err", 32'(err_o), 32'd0);
         if (k == 255) begin
            check("noinj_word256", 32'(word_ct), 32'd256);
            check("noinj_done_lag", 32'(done_o), 32'd0);
         end
         if (k == 256) check("noinj_done_set", 32'(done_o), 32'd1);
      end
      check("noinj_bad",  32'(bad_ct),  32'd0);
      check("noinj_word", 32'(word_ct), 32'd256);
      check("noinj_done", 32'(done_o),  32'd1);

      // Injection enabled, N=1: compare every symbol against the model
      do_reset();
      for (int k = 0; k < 300; k++) begin
         s = 2'($urandom_range(0, 3));
         model_step(1'b1, 1'b1, mk);
         drive(1'b1, 1'b1, s);
         check("inj_sym", 32'(sym_o), 32'(s ^ mk));
         check("inj_err", 32'(err_o), 32'(mk));
      end
      check("inj_word", 32'(word_ct),  32'(m_word));
      check("inj_bad",  32'(bad_ct),   32'(m_bad));
      check("inj_done", 32'(done_o),   32'd1);
      check("inj_lfsr", dut.lfsr,      m_lfsr);
      check("sat_bad",  32'(bad_ct2),  32'(m2_bad));
      check("sat_word", 32'(word_ct2), 32'd12);
      check("sat_done", 32'(done_o2),  32'd1);

      // valid_i toggling: valid_o is a one-cycle delay, LFSR frozen on idle cycles
      do_reset();
      prev_v = 1'b0;
      for (int k = 0; k < 20; k++) begin
         model_step(k[0], 1'b1, mk);
         drive(k[0], 1'b1, 2'b10);
         check("tog_valid", 32'(valid_o), 32'(k[0]));
         check("tog_lfsr",  dut.lfsr,     m_lfsr);
         if (k[0]) check("tog_err", 32'(err_o), 32'(mk));
         prev_v = k[0];
      end
      drive(1'b0, 1'b1, 2'b00);
      check("tog_valid_tail", 32'(valid_o), 32'(prev_v & 1'b0));

      // Reset in the middle of a window (and of a burst when compiled in)
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 250 && !found; k++) begin
         model_step(1'b1, 1'b1, mk);
         drive(1'b1, 1'b1, 2'b00);
         if (m_word >= 100 && (m_burst || !BURST_ON)) found = 1'b1;
      end
      check("mid_found", 32'(found), 32'd1);
      check("mid_word",  32'(word_ct), 32'(m_word));
      rst = 1'b1;
      valid = 1'b1;
      inj = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_sym",   32'(sym_o),   32'd0);
      check("mid_rst_valid", 32'(valid_o), 32'd0);
      check("mid_rst_err",   32'(err_o),   32'd0);
      check("mid_rst_bad",   32'(bad_ct),  32'd0);
      check("mid_rst_word",  32'(word_ct), 32'd0);
      check("mid_rst_done",  32'(done_o),  32'd0);
      check("mid_rst_lfsr",  dut.lfsr,     SEED);
      rst = 1'b0;
      // After reset: seed hits, then symbol 2 has LFSR bit0=0 and must be clean
      drive(1'b1, 1'b1, 2'b01);
      check("post_s0_err", 32'(err_o), 32'd3);
      drive(1'b1, 1'b1, 2'b01);
      check("post_s1_err", 32'(err_o), 32'd3);
      drive(1'b1, 1'b1, 2'b01);
      check("post_s2_err", 32'(err_o), 32'd0);
      check("post_s2_sym", 32'(sym_o), 32'd1);
      check("post_word",   32'(word_ct), 32'd3);
      check("post_bad",    32'(bad_ct),  32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
